ds_inst_queue: RTL and testbench
================================

DS_INST_QUEUE -- requirements
Module: ds_inst_queue

Interface
REQ-001 SHALL have parameter DATA_WD, default 64, meaning width of the fetch-to-decode payload {inst, pc}.
REQ-002 SHALL have parameter EX_WD, default 1, meaning width of the fetch exception/branch-delay side bus.
REQ-003 SHALL have parameter DEPTH, default 4, meaning entry count; legal values are powers of two >= 2.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port fs_to_ds_valid  input  1  fetch offers an entry.
REQ-007 SHALL have port fs_to_ds_bus  input  DATA_WD  entry payload.
REQ-008 SHALL have port fs_ex_bus  input  EX_WD  entry side bus, stored alongside the payload.
REQ-009 SHALL have port iq_allowin  output  1  the queue accepts a write this cycle.
REQ-010 SHALL have port iq_to_ds_valid  output  1  the head entry is valid.
REQ-011 SHALL have port iq_to_ds_bus  output  DATA_WD  head payload.
REQ-012 SHALL have port iq_ex_bus  output  EX_WD  head side bus.
REQ-013 SHALL have port ds_allowin  input  1  decode consumes the head this cycle.
REQ-014 SHALL have port flush  input  1  exception/eret flush from cp0.
REQ-015 SHALL have port br_redirect  input  1  one-cycle pulse when decode resolves a taken branch/jump.
REQ-016 SHALL have port iq_count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-017 SHALL implement a circular FIFO with read pointer, write pointer and count; pointers wrap modulo DEPTH.
REQ-018 SHALL drive iq_allowin = (count != DEPTH), independent of ds_allowin, so a full queue accepts no write even when a read occurs.
REQ-019 SHALL perform a write when fs_to_ds_valid && iq_allowin, storing fs_to_ds_bus and fs_ex_bus at the write pointer.
REQ-020 SHALL drive iq_to_ds_valid = (count != 0), with iq_to_ds_bus/iq_ex_bus taken combinationally from the head entry; bus values are don't-care when iq_to_ds_valid is low.
REQ-021 SHALL perform a read when iq_to_ds_valid && ds_allowin, advancing the read pointer.
REQ-022 SHALL provide no bypass: a written entry is first visible at the head one cycle after the write (latency 1).
REQ-023 SHALL leave count unchanged on a simultaneous read and write, and update it by +1 on write only and by -1 on read only.
REQ-024 SHALL, on flush, set count to 0 and read pointer = write pointer, discarding any same-cycle write; flush has priority over br_redirect.
REQ-025 SHALL, on br_redirect with count > 0 and no read, retain only the head entry (count = 1) and drop any same-cycle write.
REQ-026 SHALL, on br_redirect with count > 0 and a read, deliver the head and become empty (count = 0), dropping any same-cycle write.
REQ-027 SHALL, on br_redirect with count = 0, retain a same-cycle write as the sole entry (the delay slot), otherwise remain empty.
REQ-028 SHALL drive iq_count equal to the registered count at all times.

Reset
REQ-029 SHALL, while reset is high at a clock edge, set count, read pointer and write pointer to 0, regardless of flush, br_redirect or write/read requests.
REQ-030 SHALL drive iq_to_ds_valid = 0, iq_allowin = 1 and iq_count = 0 in the cycle after reset.
REQ-031 SHALL require no reset of entry storage.

Verification
REQ-032 SHALL be covered by this scenario: DEPTH=4, write 5 entries back-to-back with ds_allowin=0 -> iq_allowin falls after the 4th; the 5th is held off; iq_count=4; the head is the 1st entry.
REQ-033 SHALL be covered by this scenario: full queue, fs_to_ds_valid=1, ds_allowin=1 for 1 cycle -> one read, no write, iq_count=3, iq_allowin=1 the next cycle.
REQ-034 SHALL be covered by this scenario: count=2, simultaneous read and write for 8 cycles with pc increments 4 -> pc order preserved across pointer wrap, count stays 2.
REQ-035 SHALL be covered by this scenario: count=3 with heads pc 0x100/0x104/0x108, br_redirect=1, ds_allowin=0 -> count=1, head pc 0x100; with ds_allowin=1 instead -> 0x100 delivered, count=0.
REQ-036 SHALL be covered by this scenario: count=0, br_redirect=1 with a write of pc 0x200 -> count=1, head 0x200 next cycle; flush+br_redirect+write together -> count=0.
REQ-037 SHALL be covered by this scenario: count=3, reset asserted for 1 cycle mid-stream alongside a write -> count=0, iq_to_ds_valid=0, iq_allowin=1.

Source files
------------

// File: rtl/ds_inst_queue.sv
`default_nettype none
// ============================================================================
//  Module   : ds_inst_queue
//  Purpose  : Circular instruction queue between fetch and decode. It holds
//             up to DEPTH {inst, pc} entries with a side exception bus.
//             Flush empties the queue. A branch redirect keeps only the
//             head entry, which is the delay slot.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             fs_to_ds_valid/bus  - write request and payload from fetch
//             fs_ex_bus           - side bus stored with each entry
//             iq_allowin          - queue can take a write this cycle
//             iq_to_ds_valid/bus  - head entry presented to decode
//             iq_ex_bus           - head side bus
//             ds_allowin          - decode consumes the head this cycle
//             flush, br_redirect  - pipeline kill controls
//             iq_count            - current occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module ds_inst_queue #(
  parameter int DATA_WD = 64,
  parameter int EX_WD   = 1,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fs_to_ds_valid,
  input  logic [DATA_WD-1:0]       fs_to_ds_bus,
  input  logic [EX_WD-1:0]         fs_ex_bus,
  output logic                     iq_allowin,
  output logic                     iq_to_ds_valid,
  output logic [DATA_WD-1:0]       iq_to_ds_bus,
  output logic [EX_WD-1:0]         iq_ex_bus,
  input  logic                     ds_allowin,
  input  logic                     flush,
  input  logic                     br_redirect,
  output logic [$clog2(DEPTH):0]   iq_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

  logic [DATA_WD-1:0] r_data [DEPTH];
  logic [EX_WD-1:0]   r_ex   [DEPTH];
  logic [PTR_W-1:0]   r_rptr;
  logic [PTR_W-1:0]   r_wptr;
  logic [CNT_W-1:0]   r_count;

  logic w_wr;
  logic w_rd;
  logic w_wr_commit;
  logic w_br_kill;

  assign iq_allowin     = (r_count != c_FULL);
  assign iq_to_ds_valid = (r_count != '0);
  assign iq_to_ds_bus   = r_data[r_rptr];
  assign iq_ex_bus      = r_ex[r_rptr];
  assign iq_count       = r_count;

  assign w_wr = fs_to_ds_valid && iq_allowin;
  assign w_rd = iq_to_ds_valid && ds_allowin;

  // A redirect with a non-empty queue kills everything younger than the
  // head. With an empty queue, the same-cycle write is the delay slot and
  // must survive.
  assign w_br_kill   = br_redirect && (r_count != '0);
  assign w_wr_commit = w_wr && !flush && !w_br_kill;

  // Entry storage carries no reset. Valid state is held in the pointers
  // and the count.
  always_ff @(posedge clk) begin
    if (w_wr_commit) begin
      r_data[r_wptr] <= fs_to_ds_bus;
      r_ex[r_wptr]   <= fs_ex_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_rptr  <= r_wptr;
      r_count <= '0;
    end else if (w_br_kill) begin
      // Rewind the write pointer to just past the head. If the head is
      // consumed this cycle, both pointers land there and the queue is empty.
      r_wptr <= r_rptr + 1'b1;
      if (w_rd) begin
        r_rptr  <= r_rptr + 1'b1;
        r_count <= '0;
      end else begin
        r_count <= c_ONE;
      end
    end else begin
      if (w_wr_commit) r_wptr <= r_wptr + 1'b1;
      if (w_rd)        r_rptr <= r_rptr + 1'b1;
      case ({w_wr_commit, w_rd})
        2'b10:   r_count <= r_count + c_ONE;
        2'b01:   r_count <= r_count - c_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ds_inst_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ds_inst_queue
//  Purpose  : Self-checking bench for ds_inst_queue. A reference queue
//             model keeps the entries the design should currently hold. A
//             monitor compares the design outputs against the model on
//             every falling edge and pops an entry on each consumed head.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ds_inst_queue;

  localparam int DATA_WD = 64;
  localparam int EX_WD   = 1;
  localparam int DEPTH   = 4;

  typedef struct {
    logic [DATA_WD-1:0] bus;
    logic [EX_WD-1:0]   ex;
  } entry_t;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   fs_to_ds_valid = 1'b0;
  logic [DATA_WD-1:0]     fs_to_ds_bus = '0;
  logic [EX_WD-1:0]       fs_ex_bus = '0;
  logic                   iq_allowin;
  logic                   iq_to_ds_valid;
  logic [DATA_WD-1:0]     iq_to_ds_bus;
  logic [EX_WD-1:0]       iq_ex_bus;
  logic                   ds_allowin = 1'b0;
  logic                   flush = 1'b0;
  logic                   br_redirect = 1'b0;
  logic [$clog2(DEPTH):0] iq_count;

  ds_inst_queue #(.DATA_WD(DATA_WD), .EX_WD(EX_WD), .DEPTH(DEPTH)) u_dut (
    .clk            (clk),
    .reset          (reset),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .fs_ex_bus      (fs_ex_bus),
    .iq_allowin     (iq_allowin),
    .iq_to_ds_valid (iq_to_ds_valid),
    .iq_to_ds_bus   (iq_to_ds_bus),
    .iq_ex_bus      (iq_ex_bus),
    .ds_allowin     (ds_allowin),
    .flush          (flush),
    .br_redirect    (br_redirect),
    .iq_count       (iq_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  // Expected contents: oldest entry at index 0.
  entry_t sb[$];

  // Inputs applied for the coming edge, plus the model size before it.
  logic   s_v = 1'b0, s_rdy = 1'b0, s_fl = 1'b0, s_br = 1'b0, s_rst = 1'b1;
  entry_t s_ent;
  int     s_size0 = 0;

  int exp_count = 0;
  bit exp_valid = 1'b0;
  bit exp_allowin = 1'b1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: compare status every cycle, check the head and pop on consume.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", 64'(iq_count), 64'(exp_count));
      chk("valid", 64'(iq_to_ds_valid), 64'(exp_valid));
      chk("allowin", 64'(iq_allowin), 64'(exp_allowin));
      if (iq_to_ds_valid === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL head_unexpected actual=valid expected=empty at %0t", $time);
        end else begin
          chk("head_bus", iq_to_ds_bus, sb[0].bus);
          chk("head_ex", 64'(iq_ex_bus), 64'(sb[0].ex));
          if (ds_allowin) void'(sb.pop_front());
        end
      end
    end
  end

  // Apply the rules to the model for the edge that just happened. Any
  // consumed head has already been popped by the monitor.
  task automatic apply_model();
    if (s_rst || s_fl) begin
      sb.delete();
    end else if (s_br && s_size0 != 0) begin
      if (s_rdy) sb.delete();
      else while (sb.size() > 1) void'(sb.pop_back());
    end else if (s_v && s_size0 != DEPTH) begin
      sb.push_back(s_ent);
    end
  endtask

  task automatic cyc(input logic v, input logic [31:0] pc, input logic rdy,
                     input logic fl, input logic br, input logic rst);
    @(posedge clk);
    apply_model();
    #1;
    s_v        = v;
    s_rdy      = rdy;
    s_fl       = fl;
    s_br       = br;
    s_rst      = rst;
    s_ent.bus  = {$urandom(), pc};
    s_ent.ex   = EX_WD'($urandom());
    s_size0    = sb.size();
    exp_count   = sb.size();
    exp_valid   = (sb.size() != 0);
    exp_allowin = (sb.size() != DEPTH);
    fs_to_ds_valid = v;
    fs_to_ds_bus   = s_ent.bus;
    fs_ex_bus      = s_ent.ex;
    ds_allowin     = rdy;
    flush          = fl;
    br_redirect    = br;
    reset          = rst;
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [31:0] pc;

  initial begin
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'hdead, 1'b1, 1'b1, 1'b1, 1'b1);
    mon_en = 1'b1;
    idle();
    @(negedge clk);
    chk("rst_count", 64'(iq_count), 64'd0);
    chk("rst_allowin", 64'(iq_allowin), 64'd1);

    // Fill the queue: the fifth write must be held off.
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h1000 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("full_count", 64'(iq_count), 64'd4);
    chk("full_allowin", 64'(iq_allowin), 64'd0);
    chk("full_head_pc", 64'(iq_to_ds_bus[31:0]), 64'h1000);

    // A full queue with a write and a read: only the read happens.
    cyc(1'b1, 32'h2000, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("full_rw_count", 64'(iq_count), 64'd3);
    chk("full_rw_allowin", 64'(iq_allowin), 64'd1);

    // Streaming across the pointer wrap with two entries held.
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h3000 + 32'(4 * i), 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("stream_count", 64'(iq_count), 64'd2);

    // Redirect without a read keeps the head, with a read it empties the queue.
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h10c, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    chk("br_keep_count", 64'(iq_count), 64'd1);
    chk("br_keep_head_pc", 64'(iq_to_ds_bus[31:0]), 64'h100);
    cyc(1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h108, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h10c, 1'b1, 1'b0, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    chk("br_read_count", 64'(iq_count), 64'd0);

    // On an empty queue, the write that comes with a redirect is kept as the delay slot.
    cyc(1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    chk("br_empty_count", 64'(iq_count), 64'd1);
    chk("br_empty_head_pc", 64'(iq_to_ds_bus[31:0]), 64'h200);
    cyc(1'b1, 32'h204, 1'b0, 1'b1, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    chk("flush_br_count", 64'(iq_count), 64'd0);

    // Reset in the middle of a stream, together with a write.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h400 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h40c, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    chk("mid_rst_count", 64'(iq_count), 64'd0);
    chk("mid_rst_valid", 64'(iq_to_ds_valid), 64'd0);
    chk("mid_rst_allowin", 64'(iq_allowin), 64'd1);

    // Randomised traffic against the model.
    pc = 32'hbfc0_0000;
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom() % 4) != 0, pc, ($urandom() % 3) != 0,
          ($urandom() % 40) == 0, ($urandom() % 12) == 0, ($urandom() % 150) == 0);
      pc = pc + 32'd4;
    end
    idle();
    idle();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
